// File: rtl/spi_pkg.sv
// Shared SPI frame definitions used by the controller and the peripheral side.
package spi_pkg;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned HP_CNT_W   = 8;
   localparam int unsigned BIT_CNT_W  = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } spi_frame_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while enabled.
module spi_tick_gen
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick_c
);

   localparam logic [HP_CNT_W-1:0] LAST = HP_CNT_W'(CLK_DIV - 1);

   logic [HP_CNT_W-1:0] cnt_q;
   logic [HP_CNT_W-1:0] cnt_d;

   // Count 0..CLK_DIV-1 while enabled; held at zero otherwise so the first tick lands CLK_DIV cycles after enable.
   always_comb begin
      cnt_d = '0;
      if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + HP_CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_c = en && (cnt_q == LAST);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master issuing one 16-bit {rw, addr, data} frame per accepted start.
module spi_controller
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              cipo,
   output logic              sclk,
   output logic              copi,
   output logic              ncs,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata
);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_BITS);
   localparam logic [BIT_CNT_W-1:0] HDR_BITS  = BIT_CNT_W'(ADDR_W + 1);
   localparam logic [3:0]           TOP_INDEX = 4'(FRAME_BITS - 1);

   spi_state_e              state_q, state_d;
   spi_frame_t              frame_q, frame_d;
   logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]       shadow_q, shadow_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic                    sclk_q, sclk_d;
   logic                    copi_q, copi_d;
   logic                    ncs_q, ncs_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [FRAME_BITS-1:0]   frame_bits;
   logic                    tick_c;

   assign frame_bits = frame_q;

   spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (state_q != ST_IDLE),
      .tick_c (tick_c)
   );

   // Next-state and output decode; every half-period tick advances the SPI waveform by one step.
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_cnt_d = bit_cnt_q;
      shadow_d  = shadow_q;
      rdata_d   = rdata_q;
      sclk_d    = sclk_q;
      copi_d    = copi_q;
      ncs_d     = ncs_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               frame_d.rw   = rw;
               frame_d.addr = addr;
               frame_d.data = rw ? wdata : '0;
               copi_d       = rw;
               ncs_d        = 1'b0;
               busy_d       = 1'b1;
               bit_cnt_d    = '0;
               state_d      = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tick_c) begin
               sclk_d    = 1'b1;
               bit_cnt_d = BIT_CNT_W'(1);
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tick_c) begin
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = ST_HOLD;
                  end else begin
                     copi_d = frame_bits[TOP_INDEX - bit_cnt_q[3:0]];
                  end
               end else begin
                  sclk_d    = 1'b1;
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  // Data phase of a read: pulses 9..16 carry the peripheral's reply.
                  if (!frame_q.rw && (bit_cnt_q >= HDR_BITS)) begin
                     shadow_d = {shadow_q[DATA_W-2:0], cipo};
                  end
               end
            end
         end
         ST_HOLD: begin
            if (tick_c) begin
               ncs_d   = 1'b1;
               copi_d  = 1'b0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tick_c) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
               if (!frame_q.rw) begin
                  rdata_d = shadow_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         frame_q   <= '0;
         bit_cnt_q <= '0;
         shadow_q  <= '0;
         rdata_q   <= '0;
         sclk_q    <= 1'b0;
         copi_q    <= 1'b0;
         ncs_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         bit_cnt_q <= bit_cnt_d;
         shadow_q  <= shadow_d;
         rdata_q   <= rdata_d;
         sclk_q    <= sclk_d;
         copi_q    <= copi_d;
         ncs_q     <= ncs_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign sclk  = sclk_q;
   assign copi  = copi_q;
   assign ncs   = ncs_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: D=4 instance with a register-file peripheral model, D=1 instance for back-to-back frames.
`timescale 1ns/1ps
module tb_spi_controller;

   localparam int D4 = 4;
   localparam int D1 = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start4 = 1'b0, rw4 = 1'b0, cipo4 = 1'b0;
   logic [6:0] addr4  = '0;
   logic [7:0] wdata4 = '0;
   logic       sclk4, copi4, ncs4, busy4, done4;
   logic [7:0] rdata4;

   logic       start1 = 1'b0, rw1 = 1'b0, cipo1 = 1'b0;
   logic [6:0] addr1  = '0;
   logic [7:0] wdata1 = '0;
   logic       sclk1, copi1, ncs1, busy1, done1;
   logic [7:0] rdata1;

   spi_controller #(.CLK_DIV(D4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .rw(rw4), .addr(addr4), .wdata(wdata4),
      .cipo(cipo4), .sclk(sclk4), .copi(copi4), .ncs(ncs4), .busy(busy4), .done(done4), .rdata(rdata4)
   );

   spi_controller #(.CLK_DIV(D1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw1), .addr(addr1), .wdata(wdata1),
      .cipo(cipo1), .sclk(sclk1), .copi(copi1), .ncs(ncs1), .busy(busy1), .done(done1), .rdata(rdata1)
   );

   int errors = 0;
   int checks = 0;

   // Reference register contents and last-read value, updated from the requests issued.
   logic [7:0] exp_mem [128];
   logic [7:0] exp_rdata = 8'h00;

   // Peripheral model: shifts in the frame on sclk rises, replies on falls, commits writes on ncs rise.
   logic [7:0]  pmem [128];
   logic [15:0] p_sh     = '0;
   logic [7:0]  p_out    = '0;
   int          p_cnt    = 0;
   int          p_writes = 0;
   logic        p_init   = 1'b0;

   always @(posedge sclk4 or posedge ncs4) begin
      if (!p_init && rst_n === 1'b1) begin
         for (int i = 0; i < 128; i++) pmem[i] = exp_mem[i];
         p_init = 1'b1;
      end
      if (ncs4) begin
         if (p_cnt == 16 && p_sh[15]) begin
            pmem[p_sh[14:8]] = p_sh[7:0];
            p_writes++;
         end
         p_cnt = 0;
      end else begin
         p_sh = {p_sh[14:0], copi4};
         p_cnt++;
      end
   end

   always @(negedge sclk4) begin
      if (!ncs4 && p_cnt >= 8 && p_cnt < 16) begin
         if (p_cnt == 8) p_out = pmem[p_sh[6:0]];
         cipo4 = p_out[15 - p_cnt];
      end
   end

   task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s @E%0d: observed 0x%0h expected 0x%0h", tag, n, obs, exp);
      end
   endtask

   // Expected {sclk, ncs, busy, done} after edge En of a frame accepted at E0, from the edge arithmetic.
   function automatic logic [3:0] exp_wave(input int d, input int n);
      logic s, c, b, dn;
      s  = (n >= d) && (n < 32 * d) && (((n - d) / d) % 2 == 0);
      c  = (n >= 33 * d);
      b  = (n < 34 * d);
      dn = (n == 34 * d);
      return {s, c, b, dn};
   endfunction

   // One frame on the D=4 instance, checked every cycle; optional extra start pulse and reset abort.
   task automatic run_frame(input string name, input logic r, input logic [6:0] a, input logic [7:0] w,
                            input int restart_at, input int abort_at);
      logic [15:0] fr;
      logic [3:0]  ew;
      logic [7:0]  exp_rd;
      logic [7:0]  mem_before;
      logic        prev_s;
      int          pulses, done_cnt, wr_before, k;
      bit          aborted;
      fr         = {r, a, (r ? w : 8'h00)};
      wr_before  = p_writes;
      mem_before = exp_mem[a];
      pulses     = 0;
      done_cnt   = 0;
      prev_s     = 1'b0;
      aborted    = 1'b0;
      @(negedge clk);
      rw4 = r; addr4 = a; wdata4 = w; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0; rw4 = ~r; addr4 = ~a; wdata4 = ~w;
      for (int n = 0; n <= 34 * D4 + 3; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         ew = exp_wave(D4, n);
         chk({name, "/sclk"}, n, sclk4, ew[3]);
         chk({name, "/ncs"},  n, ncs4,  ew[2]);
         chk({name, "/busy"}, n, busy4, ew[1]);
         chk({name, "/done"}, n, done4, ew[0]);
         exp_rd = (n >= 34 * D4 && !r) ? exp_mem[a] : exp_rdata;
         chk({name, "/rdata"}, n, rdata4, exp_rd);
         if (n == 0) chk({name, "/copi_e0"}, n, copi4, fr[15]);
         if (n >= D4 && n < 32 * D4 && (n - D4) % (2 * D4) == 0) begin
            k = (n - D4) / (2 * D4);
            chk({name, "/copi_rise"}, n, copi4, fr[15 - k]);
         end
         if (n >= 33 * D4) chk({name, "/copi_idle"}, n, copi4, 1'b0);
         if (sclk4 && !prev_s) pulses++;
         prev_s = sclk4;
         if (done4) done_cnt++;
         if (n == restart_at - 1) start4 = 1'b1;
         if (n == restart_at)     start4 = 1'b0;
         if (n == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk({name, "/abort_ncs"},   n, ncs4,   1'b1);
            chk({name, "/abort_sclk"},  n, sclk4,  1'b0);
            chk({name, "/abort_busy"},  n, busy4,  1'b0);
            chk({name, "/abort_rdata"}, n, rdata4, 8'h00);
            aborted = 1'b1;
            break;
         end
      end
      if (aborted) begin
         exp_rdata = 8'h00;
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk({name, "/abort_nodone"}, i, done4, 1'b0);
         end
         @(negedge clk);
         rst_n = 1'b1;
         chk({name, "/abort_reg"},    0, pmem[a],  mem_before);
         chk({name, "/abort_writes"}, 0, p_writes, wr_before);
      end else begin
         chk({name, "/pulses"},   0, pulses,   16);
         chk({name, "/done_cnt"}, 0, done_cnt, 1);
         if (r) exp_mem[a] = w;
         else   exp_rdata  = exp_mem[a];
         chk({name, "/reg"},    a, pmem[a],  exp_mem[a]);
         chk({name, "/writes"}, 0, p_writes, wr_before + (r ? 1 : 0));
      end
   endtask

   // D=1 instance with start held high: frames every 34D+1 cycles.
   task automatic run_held();
      logic [15:0] fr;
      logic [3:0]  ew;
      logic        prev_s, prev_c;
      int          nn, pulses, hi_run, last_fall, k;
      fr        = {1'b1, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255))};
      pulses    = 0;
      hi_run    = 0;
      last_fall = -1;
      prev_s    = 1'b0;
      prev_c    = 1'b1;
      @(negedge clk);
      rw1 = fr[15]; addr1 = fr[14:8]; wdata1 = fr[7:0]; start1 = 1'b1;
      @(posedge clk); #1;
      for (int n = 0; n < 3 * 35; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         nn = n % 35;
         ew = exp_wave(D1, nn);
         chk("held/sclk", n, sclk1, ew[3]);
         chk("held/ncs",  n, ncs1,  ew[2]);
         chk("held/busy", n, busy1, ew[1]);
         chk("held/done", n, done1, ew[0]);
         if (nn >= D1 && nn < 32 * D1 && (nn - D1) % (2 * D1) == 0) begin
            k = (nn - D1) / (2 * D1);
            chk("held/copi_rise", n, copi1, fr[15 - k]);
         end
         if (sclk1 && !prev_s) pulses++;
         prev_s = sclk1;
         if (nn == 34) begin
            chk("held/pulses", n, pulses, 16);
            pulses = 0;
         end
         if (ncs1) hi_run++;
         if (!ncs1 && prev_c) begin
            if (last_fall >= 0) begin
               chk("held/period", n, n - last_fall, 35);
               chk("held/gap_ok", n, (hi_run >= D1) ? 1 : 0, 1);
            end
            last_fall = n;
            hi_run    = 0;
         end
         prev_c = ncs1;
      end
      start1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("held/stop_busy", 0, busy1, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) exp_mem[i] = 8'($urandom_range(0, 255));
      exp_mem[2] = 8'h3C;
      exp_mem[4] = 8'h00;

      repeat (2) @(posedge clk);
      #1;
      chk("rst/sclk",  0, sclk4,  1'b0);
      chk("rst/copi",  0, copi4,  1'b0);
      chk("rst/ncs",   0, ncs4,   1'b1);
      chk("rst/busy",  0, busy4,  1'b0);
      chk("rst/done",  0, done4,  1'b0);
      chk("rst/rdata", 0, rdata4, 8'h00);
      chk("rst/ncs1",  0, ncs1,   1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run_frame("wr04", 1'b1, 7'h04, 8'hA5, -1, -1);
      chk("wr04/reg4", 4, pmem[4], 8'hA5);
      run_frame("rd02", 1'b0, 7'h02, 8'h77, -1, -1);
      chk("rd02/rdata", 2, rdata4, 8'h3C);
      run_frame("restart", 1'b1, 7'h11, 8'h5A, 50, -1);
      run_held();

      for (int t = 0; t < 4; t++) begin
         run_frame("rand", 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                   8'($urandom_range(0, 255)), -1, -1);
      end

      run_frame("abort", 1'b1, 7'h04, 8'h3E, -1, 70);
      chk("abort/reg4", 4, pmem[4], 8'hA5);
      run_frame("resume", 1'b0, 7'h04, 8'h00, -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, SCLK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a transaction; accepted only when busy=0.
REQ-005 SHALL have port rw  input  1  frame bit 15: 1=write, 0=read.
REQ-006 SHALL have port addr  input  7  register address, frame bits 14:8.
REQ-007 SHALL have port wdata  input  8  write data, frame bits 7:0.
REQ-008 SHALL have port cipo  input  1  serial data from peripheral, used for reads.
REQ-009 SHALL have port sclk  output  1  SPI clock, mode 0, idle low.
REQ-010 SHALL have port copi  output  1  serial data to peripheral, MSB first.
REQ-011 SHALL have port ncs  output  1  chip select, active-low.
REQ-012 SHALL have port busy  output  1  high from the accept edge until done.
REQ-013 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-014 SHALL have port rdata  output  8  data captured on the last read; held until the next read completes.

Function
REQ-015 SHALL latch rw, addr and wdata into a 16-bit frame {rw, addr, wdata} at the accepting edge E0; input changes afterwards have no effect.
REQ-016 SHALL drive the data field as 0 on copi when rw=0.
REQ-017 SHALL use states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, with all outputs registered.
REQ-018 SHALL at E0 drive ncs=0, copi=frame[15], busy=1, and enter SETUP.
REQ-019 SHALL have D=CLK_DIV; SCLK rising edges occur at E(D+2D*k) and falling edges at E(2D+2D*k), for k=0..15 (exactly 16 pulses).
REQ-020 SHALL update copi to the next frame bit on the same edge that sclk falls, so copi is stable for D cycles before each rise.
REQ-021 SHALL on a read sample cipo on the clk edge on which sclk rises for pulses 9..16 (MSB first) into a shadow register.
REQ-022 SHALL after the last fall (E32D) hold ncs low through E33D, then drive ncs=1, copi=0 and enter GAP.
REQ-023 SHALL at E34D return to IDLE with busy=0 and done=1 for exactly one cycle; on a read, rdata updates from the shadow register on that same edge.
REQ-024 SHALL guarantee ncs high for at least D cycles between frames; if start is held high continuously, the next frame is accepted at E34D+1 at the earliest.
REQ-025 SHALL ignore start while busy=1, with no queuing.
REQ-026 SHALL use a half-period counter of 8 bits and a bit counter of 5 bits; neither may wrap mid-frame.

Reset
REQ-027 SHALL while rst_n=0 force state=IDLE, sclk=0, copi=0, ncs=1, busy=0, done=0, rdata=0x00, frame and counters to 0.
REQ-028 SHALL treat reset mid-frame as an abort: ncs rises immediately, no done pulse, rdata=0; after rst_n deasserts, operation resumes from IDLE.

Structure
REQ-029 SHALL place FRAME_BITS=16, ADDR_W=7, DATA_W=8 and the state enum in shared package spi_pkg, which the peripheral side also uses.
REQ-030 SHALL instantiate one sub-module, spi_tick_gen, which produces a one-cycle half-period tick every CLK_DIV cycles while enabled.

Verification
REQ-031 SHALL cover: D=4, write addr=0x04, wdata=0xA5 -> copi bits 1,0000100,10100101 sampled on the 16 rises; done at E136; a peripheral model reports register 4 = 0xA5.
REQ-032 SHALL cover: read addr=0x02, with the model driving 0x3C on cipo -> copi data bits all 0; rdata=0x3C at done; no register write occurs.
REQ-033 SHALL cover: start pulsed again at E50 during a frame -> ignored; exactly 16 sclk pulses and one done.
REQ-034 SHALL cover: start held high, D=1 -> frames repeat every 35 cycles, with ncs high for at least 1 cycle between frames and 16 pulses per frame.
REQ-035 SHALL cover: rst_n low at E70 of a write -> ncs=1, sclk=0 and busy=0 immediately, no done pulse, and the model's register unchanged.
